// File: rtl/systolic_feeder.sv
// systolic_feeder: operand sequencer for an NxN PE array. Accepts one K-slice per
// beat (column k of A, row k of B), skews lane i / j by i / j cycles onto the left
// and top array edges, drives each PE's clear when its first operand pair arrives,
// and pulses done once every accumulator holds the complete K-term dot product.
// Optional feature: define FEEDER_ABORT_EN to add the abort input.
module systolic_feeder #(
   parameter int N  = 2,
   parameter int DW = 8,
   parameter int KW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
`ifdef FEEDER_ABORT_EN
   input  logic            abort,
`endif
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] a_col,
   input  logic [N*DW-1:0] b_row,
   output logic [N*DW-1:0] a_edge,
   output logic [N*DW-1:0] b_edge,
   output logic [N*N-1:0]  clear_pe,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(2*N) + 1;   // drain counter width
   localparam int TD = 2*N - 1;           // first-beat token reaches PE(N-1,N-1) after TD stages

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [KW-1:0] k_reg;
   logic [KW-1:0] beat_cnt;
   logic [CW-1:0] drain_cnt;
   logic [TD-1:0] clr_vld_p;
   logic          kill;
   logic          launch;
   logic          accept;
   logic          first_beat;
   logic          last_beat;

`ifdef FEEDER_ABORT_EN
   assign kill = abort && (state != IDLE);
`else
   assign kill = 1'b0;
`endif

   assign launch     = (state == IDLE) && start && (k_len != '0);
   assign accept     = (state == STREAM) && (beat_cnt < k_reg) && in_valid && !kill;
   assign first_beat = accept && (beat_cnt == '0);
   assign last_beat  = accept && (beat_cnt == k_reg - KW'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake/status outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (launch) state_nxt = STREAM;
         end
         STREAM: begin
            busy     = 1'b1;
            in_ready = (beat_cnt < k_reg);
            if (kill)           state_nxt = IDLE;
            else if (last_beat) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (kill) begin
               state_nxt = IDLE;
            end else if (drain_cnt == CW'(2*N - 1)) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Tile length latch, beat counter (saturates at K) and drain counter
   always_ff @(posedge clk) begin
      if (rst) begin
         k_reg     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (launch) begin
            k_reg    <= k_len;
            beat_cnt <= '0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
         end
         if (state == DRAIN) drain_cnt <= drain_cnt + CW'(1);
         else                drain_cnt <= '0;
      end
   end

   // First-beat token delay line; stage s reaches every PE with i+j == s
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         clr_vld_p <= '0;
      end else begin
         clr_vld_p[0] <= first_beat;
         for (int s = 1; s < TD; s++) clr_vld_p[s] <= clr_vld_p[s-1];
      end
   end

   // Fan the token stages out to the per-PE clear bits
   always_comb begin
      clear_pe = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            clear_pe[i*N + j] = clr_vld_p[i + j];
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] a_p [0:i];
      logic [DW-1:0] b_p [0:i];

      // Lane i skew line: i+1 stages, zero injected whenever no beat is accepted
      always_ff @(posedge clk) begin
         if (rst || kill) begin
            for (int s = 0; s <= i; s++) begin
               a_p[s] <= '0;
               b_p[s] <= '0;
            end
         end else begin
            a_p[0] <= accept ? a_col[i*DW +: DW] : '0;
            b_p[0] <= accept ? b_row[i*DW +: DW] : '0;
            for (int s = 1; s <= i; s++) begin
               a_p[s] <= a_p[s-1];
               b_p[s] <= b_p[s-1];
            end
         end
      end

      assign a_edge[i*DW +: DW] = a_p[i];
      assign b_edge[i*DW +: DW] = b_p[i];
   end

endmodule
